// File: rtl/reaction_pkg.sv
// Shared FSM state type and width helpers for the reaction game controller.
package reaction_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DELAY,
      LIT,
      RECORD,
      DONE,
      FAULT
   } state_t;

   // Bits needed to hold 0..max_ms.
   function automatic int ms_width(input int max_ms);
      return $clog2(max_ms + 1);
   endfunction

   // Bits needed for the longest pre-light delay the random input can request.
   function automatic int delay_width(input int min_ms, input int step_ms, input int rnd_w);
      return $clog2(min_ms + ((1 << rnd_w) - 1) * step_ms + 1);
   endfunction

endpackage

// File: rtl/reaction_edge_detect.sv
// Registered rising-edge detector; both stages come out of reset high.
module reaction_edge_detect #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] level,
   output logic [W-1:0] rise
);

   logic [W-1:0] cur;
   logic [W-1:0] prev;

   // NOTE: resetting to ones means a button already held at reset release never looks like a new press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur  <= '1;
         prev <= '1;
      end else begin
         cur  <= level;
         prev <= cur;
      end
   end

   assign rise = cur & ~prev;

endmodule

// File: rtl/reaction_game_ctrl.sv
// Multi-round, multi-button reaction game controller with last/best/average timing.
// Optional feature: define REACTION_FALSE_START_EN to fault on a button edge before the LED lights.
module reaction_game_ctrl
   import reaction_pkg::*;
#(
   parameter int MAX_MS        = 2047,
   parameter int LED_NUM       = 17,
   parameter int NUM_BTN       = 4,
   parameter int NUM_ROUNDS    = 4,
   parameter int MIN_DELAY_MS  = 500,
   parameter int DELAY_STEP_MS = 64,
   localparam int MS_W   = ms_width(MAX_MS),
   localparam int RND_W  = $clog2(LED_NUM),
   localparam int RIDX_W = $clog2(NUM_ROUNDS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick_ms,
   input  logic               start_pressed,
   input  logic [NUM_BTN-1:0] button_pressed,
   input  logic [RND_W-1:0]   random_value,
   output logic [LED_NUM-1:0] led_on,
   output logic [MS_W-1:0]    result_ms,
   output logic [MS_W-1:0]    best_ms,
   output logic [MS_W-1:0]    avg_ms,
   output logic [RIDX_W-1:0]  round_idx,
   output logic               busy,
   output logic               done,
   output logic               false_start
);

   localparam int TGT_W = $clog2(NUM_BTN);
   localparam int DLY_W = delay_width(MIN_DELAY_MS, DELAY_STEP_MS, RND_W);
   localparam int SUM_W = MS_W + RIDX_W;
   localparam logic [MS_W-1:0]   MS_MAX    = MS_W'(MAX_MS);
   localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(NUM_ROUNDS - 1);

   logic               start_rise;
   logic [NUM_BTN-1:0] btn_rise;
   logic               tick_q;
   logic [RND_W-1:0]   rnd_q;

   reaction_edge_detect #(.W(1)) u_start_edge (
      .clk   (clk),
      .rst   (rst),
      .level (start_pressed),
      .rise  (start_rise)
   );

   reaction_edge_detect #(.W(NUM_BTN)) u_btn_edge (
      .clk   (clk),
      .rst   (rst),
      .level (button_pressed),
      .rise  (btn_rise)
   );

   // Tick and random value share the single register stage of the edge detectors.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_q <= 1'b0;
         rnd_q  <= '0;
      end else begin
         tick_q <= tick_ms;
         rnd_q  <= random_value;
      end
   end

   state_t            state;
   logic [DLY_W-1:0]  dly;
   logic [MS_W-1:0]   cnt;
   logic [TGT_W-1:0]  tgt;
   logic [MS_W-1:0]   rec_t;
   logic [SUM_W-1:0]  sum;

   logic [DLY_W-1:0]  arm_dly;
   logic [TGT_W-1:0]  arm_tgt;
   logic [SUM_W-1:0]  sum_next;
   logic              fault_hit;

   assign arm_dly  = DLY_W'(MIN_DELAY_MS) + DLY_W'(rnd_q) * DLY_W'(DELAY_STEP_MS);
   assign arm_tgt  = rnd_q[TGT_W-1:0];
   assign sum_next = sum + SUM_W'(rec_t);

`ifdef REACTION_FALSE_START_EN
   assign fault_hit = |btn_rise;
`else
   assign fault_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         dly         <= '0;
         cnt         <= '0;
         tgt         <= '0;
         rec_t       <= '0;
         sum         <= '0;
         led_on      <= '0;
         result_ms   <= '0;
         best_ms     <= MS_MAX;
         avg_ms      <= '0;
         round_idx   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         false_start <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE, FAULT: begin
               if (start_rise) begin
                  state       <= DELAY;
                  dly         <= arm_dly;
                  tgt         <= arm_tgt;
                  sum         <= '0;
                  best_ms     <= MS_MAX;
                  round_idx   <= '0;
                  led_on      <= '0;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  false_start <= 1'b0;
               end
            end
            DELAY: begin
               if (fault_hit) begin
                  state       <= FAULT;
                  led_on      <= '1;
                  busy        <= 1'b0;
                  false_start <= 1'b1;
               end else if (dly == '0) begin
                  state  <= LIT;
                  cnt    <= '0;
                  led_on <= LED_NUM'(1) << tgt;
               end else if (tick_q) begin
                  dly <= dly - 1'b1;
               end
            end
            LIT: begin
               // Correct button beats a wrong one and beats a same-cycle tick.
               if (btn_rise[tgt]) begin
                  state  <= RECORD;
                  rec_t  <= cnt;
                  led_on <= '0;
               end else if ((|btn_rise) || (cnt == MS_MAX)) begin
                  state  <= RECORD;
                  rec_t  <= MS_MAX;
                  led_on <= '0;
               end else if (tick_q) begin
                  cnt <= cnt + 1'b1;
               end
            end
            RECORD: begin
               result_ms <= rec_t;
               sum       <= sum_next;
               if (rec_t < best_ms) best_ms <= rec_t;
               if (round_idx == LAST_ROUND) begin
                  state  <= DONE;
                  avg_ms <= MS_W'(sum_next >> RIDX_W);
                  busy   <= 1'b0;
                  done   <= 1'b1;
               end else begin
                  state     <= DELAY;
                  round_idx <= round_idx + 1'b1;
                  dly       <= arm_dly;
                  tgt       <= arm_tgt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
